fp8_operand_sequencer: RTL

Sequencer that sits directly upstream of the 8-bit floating-point adder and drives it. It accepts two FP8 operands, A then B, over a single byte-wide valid/ready input channel, pulses the adder's start, and waits for its done. It then presents the sum on a byte-wide valid/ready output channel. It serialises adder traffic from the chip pins so the adder core sees stable operands and exactly one start per operation.

---
 rtl/fp8_operand_sequencer.sv | 81 ++++++++
 1 files changed

// File: rtl/fp8_operand_sequencer.sv
// fp8_operand_sequencer: loads FP8 operands A/B, drives one adder start, holds the sum for the consumer.
// Define FP8_SEQ_TIMEOUT_EN to compile in the WAIT-state watchdog and sticky err flag.
module fp8_operand_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_op_a,
  output logic [7:0] o_op_b,
  output logic       o_add_start,
  input  logic       i_add_done,
  input  logic [7:0] i_add_sum,
  output logic [7:0] o_out_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_ISSUE, S_WAIT, S_HOLD} state_t;
  state_t r_state, w_next;
  logic w_in_hs, w_timeout;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  assign o_in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign o_add_start = r_state == S_ISSUE;
  assign o_out_valid = r_state == S_HOLD;
  assign o_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_HOLD);
  assign w_in_hs     = o_in_ready && i_in_valid;
`ifdef FP8_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wd;
  logic          r_err;
  // a same-cycle add_done beats the watchdog
  assign w_timeout = (r_state == S_WAIT) && !i_add_done && (r_wd == CW'(TIMEOUT_CYCLES - 1));
  assign o_err     = r_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) r_wd <= '0;
      else if (r_state == S_WAIT && !i_add_done) r_wd <= r_wd + 1'b1;
      if (r_state == S_LOAD_A && w_in_hs) r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_LOAD_A;
      S_LOAD_A: w_next = w_in_hs ? S_LOAD_B : S_LOAD_A;
      S_LOAD_B: w_next = w_in_hs ? S_ISSUE : S_LOAD_B;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   w_next = (i_add_done || w_timeout) ? S_HOLD : S_WAIT;
      S_HOLD:   w_next = i_out_ready ? S_LOAD_A : S_HOLD;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      o_op_a     <= 8'h00;
      o_op_b     <= 8'h00;
      o_out_data <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD_A && w_in_hs) o_op_a <= i_in_data;
      if (r_state == S_LOAD_B && w_in_hs) o_op_b <= i_in_data;
      if (r_state == S_WAIT && i_add_done) o_out_data <= i_add_sum;
      else if (w_timeout) o_out_data <= 8'hFF;
    end
  end
endmodule
